// File: rtl/uart_tx_framer_if.sv
// Write-side handshake for uart_tx_framer: producer presents a byte, the
// framer reports whether its FIFO can take it.
interface uart_tx_framer_if;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit stage: small byte FIFO feeding an 8N1/8N2 framer whose bit
// timing is paced by the prescaler's scaled strobe.
module uart_tx_framer #(
   parameter int unsigned TICKS_PER_BIT = 1,
   parameter int unsigned STOP_BITS     = 1,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   scaled,
   uart_tx_framer_if.slave        wr,
   output logic                   tx,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int unsigned aw        = $clog2(DEPTH);
   localparam int unsigned tick_lim  = TICKS_PER_BIT - 1;
   localparam int unsigned stop_lim  = STOP_BITS - 1;
   localparam logic [aw:0] lvl_full  = DEPTH[aw:0];
   localparam logic [3:0]  tick_last = tick_lim[3:0];
   localparam logic        stop_last = stop_lim[0];

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e        state_q, state_d;
   logic [3:0]    tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic          stop_q, stop_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_d, busy_d;

   logic [7:0]    mem [DEPTH];
   logic [aw-1:0] wptr_q, rptr_q;
   logic [aw:0]   level_q;
   logic          push, pop, end_bit, have_data;

   assign wr.wr_ready = (level_q != lvl_full);
   assign push        = wr.wr_valid && wr.wr_ready;
   assign have_data   = (level_q != '0);
   assign end_bit     = scaled && (tick_q == tick_last);
   assign fifo_level  = level_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wptr_q] <= wr.wr_data;
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      tx_d    = tx;
      pop     = 1'b0;

      if (state_q != StIdle && scaled) tick_d = end_bit ? 4'd0 : tick_q + 4'd1;

      unique case (state_q)
         StIdle: begin
            if (scaled && have_data) begin
               pop     = 1'b1;
               shift_d = mem[rptr_q];
               tx_d    = 1'b0;
               tick_d  = 4'd0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (end_bit) begin
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            if (end_bit) begin
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
                  state_d = StStop;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (end_bit) begin
               if (stop_q == stop_last) begin
                  // Chain straight into the next start bit when more bytes wait.
                  if (have_data) begin
                     pop     = 1'b1;
                     shift_d = mem[rptr_q];
                     tx_d    = 1'b0;
                     state_d = StStart;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StIdle;
                  end
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         tx      <= tx_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: one 8N1/TICKS=1 instance and one
// 8N2/TICKS=4 instance sharing clock and reset.
module tb_uart_tx_framer;

   logic       clock;
   logic       reset;
   logic       scaled_a, scaled_b;
   logic       tx_a, tx_b, busy_a, busy_b;
   logic [2:0] level_a, level_b;
   int         total = 0;
   int         bad   = 0;

   uart_tx_framer_if wa ();
   uart_tx_framer_if wb ();

   uart_tx_framer #(.TICKS_PER_BIT(1), .STOP_BITS(1), .DEPTH(4)) dut_a (
      .clock(clock), .reset(reset), .scaled(scaled_a), .wr(wa),
      .tx(tx_a), .busy(busy_a), .fifo_level(level_a)
   );

   uart_tx_framer #(.TICKS_PER_BIT(4), .STOP_BITS(2), .DEPTH(4)) dut_b (
      .clock(clock), .reset(reset), .scaled(scaled_b), .wr(wb),
      .tx(tx_b), .busy(busy_b), .fifo_level(level_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Line values after each edge of a frame: start, d0..d7, stop.
   function automatic logic [9:0] frame10(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   task automatic test_reset();
      reset = 1'b1; scaled_a = 1'b0; scaled_b = 1'b0;
      wa.wr_valid = 1'b0; wa.wr_data = 8'h00;
      wb.wr_valid = 1'b0; wb.wr_data = 8'h00;
      step(); step();
      reset = 1'b0;
      step();
      total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL reset_tx_a got=%b want=1", tx_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
      total++; if (wa.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_a got=%b want=1", wa.wr_ready); end
      total++; if (level_a !== 3'd0) begin bad++; $display("FAIL reset_level_a got=%0d want=0", level_a); end
      total++; if (tx_b !== 1'b1 || busy_b !== 1'b0 || level_b !== 3'd0) begin
         bad++; $display("FAIL reset_b got tx=%b busy=%b lvl=%0d want 1/0/0", tx_b, busy_b, level_b);
      end
   endtask

   task automatic test_single();
      logic [9:0] want;
      want = 10'b1101001010;  // 0xA5 framed, bit 0 first
      scaled_a = 1'b1;
      wa.wr_valid = 1'b1; wa.wr_data = 8'hA5;
      step();
      wa.wr_valid = 1'b0;
      total++; if (level_a !== 3'd1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
         bad++; $display("FAIL single_write got lvl=%0d busy=%b tx=%b want 1/0/1", level_a, busy_a, tx_a);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (tx_a !== want[i]) begin bad++; $display("FAIL single_bit%0d got=%b want=%b", i, tx_a, want[i]); end
         total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL single_busy%0d got=%b want=1", i, busy_a); end
         if (i == 0) begin
            total++; if (level_a !== 3'd0) begin bad++; $display("FAIL single_pop got=%0d want=0", level_a); end
         end
      end
      step();
      total++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
         bad++; $display("FAIL single_end got busy=%b tx=%b want 0/1", busy_a, tx_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  bytes [3];
      logic [2:0]  want_lvl [3];
      logic [29:0] want;
      bytes = '{8'h00, 8'hFF, 8'h3C};
      want_lvl = '{3'd1, 3'd1, 3'd2};
      want = {frame10(8'h3C), frame10(8'hFF), frame10(8'h00)};
      scaled_a = 1'b1;
      for (int w = 0; w < 3; w++) begin
         wa.wr_valid = 1'b1; wa.wr_data = bytes[w];
         step();
         total++; if (level_a !== want_lvl[w]) begin
            bad++; $display("FAIL b2b_level%0d got=%0d want=%0d", w, level_a, want_lvl[w]);
         end
         if (w > 0) begin
            total++; if (tx_a !== want[w-1]) begin bad++; $display("FAIL b2b_bit%0d got=%b want=%b", w-1, tx_a, want[w-1]); end
         end
      end
      wa.wr_valid = 1'b0;
      for (int i = 2; i < 30; i++) begin
         step();
         total++; if (tx_a !== want[i] || busy_a !== 1'b1) begin
            bad++; $display("FAIL b2b_bit%0d got tx=%b busy=%b want tx=%b busy=1", i, tx_a, busy_a, want[i]);
         end
      end
      step();
      total++; if (busy_a !== 1'b0 || level_a !== 3'd0) begin
         bad++; $display("FAIL b2b_end got busy=%b lvl=%0d want 0/0", busy_a, level_a);
      end
   endtask

   task automatic test_full();
      logic [7:0]  bytes [4];
      logic [39:0] want;
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      want = {frame10(8'h44), frame10(8'h33), frame10(8'h22), frame10(8'h11)};
      scaled_a = 1'b0;
      wa.wr_valid = 1'b1;
      for (int w = 0; w < 4; w++) begin
         total++; if (wa.wr_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%b want=1", w, wa.wr_ready); end
         wa.wr_data = bytes[w];
         step();
         total++; if (level_a !== 3'(w + 1)) begin bad++; $display("FAIL full_level%0d got=%0d want=%0d", w, level_a, w + 1); end
      end
      wa.wr_data = 8'h77;
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (wa.wr_ready !== 1'b0 || level_a !== 3'd4) begin
            bad++; $display("FAIL full_drop%0d got rdy=%b lvl=%0d want 0/4", c, wa.wr_ready, level_a);
         end
         total++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL full_hold%0d got tx=%b busy=%b want 1/0", c, tx_a, busy_a);
         end
      end
      wa.wr_valid = 1'b0;
      scaled_a = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         total++; if (tx_a !== want[i]) begin bad++; $display("FAIL full_bit%0d got=%b want=%b", i, tx_a, want[i]); end
      end
      for (int c = 0; c < 15; c++) begin
         step();
         total++; if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) begin
            bad++; $display("FAIL full_after%0d got tx=%b busy=%b lvl=%0d want 1/0/0", c, tx_a, busy_a, level_a);
         end
      end
   endtask

   task automatic test_push_pop();
      logic [19:0] want;
      want = {frame10(8'hC3), frame10(8'h5A)};
      scaled_a = 1'b0;
      wa.wr_valid = 1'b1; wa.wr_data = 8'h5A;
      step();
      total++; if (level_a !== 3'd1) begin bad++; $display("FAIL pp_first got=%0d want=1", level_a); end
      scaled_a = 1'b1;
      wa.wr_data = 8'hC3;
      step();
      wa.wr_valid = 1'b0;
      total++; if (level_a !== 3'd1 || tx_a !== 1'b0 || busy_a !== 1'b1) begin
         bad++; $display("FAIL pp_same got lvl=%0d tx=%b busy=%b want 1/0/1", level_a, tx_a, busy_a);
      end
      for (int i = 1; i < 20; i++) begin
         step();
         total++; if (tx_a !== want[i]) begin bad++; $display("FAIL pp_bit%0d got=%b want=%b", i, tx_a, want[i]); end
      end
      step();
      total++; if (busy_a !== 1'b0 || level_a !== 3'd0) begin
         bad++; $display("FAIL pp_end got busy=%b lvl=%0d want 0/0", busy_a, level_a);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] bytes [3];
      bytes = '{8'hF0, 8'h0F, 8'hAA};
      scaled_a = 1'b0;
      wa.wr_valid = 1'b1;
      for (int w = 0; w < 3; w++) begin
         wa.wr_data = bytes[w];
         step();
      end
      wa.wr_valid = 1'b0;
      scaled_a = 1'b1;
      step();
      total++; if (level_a !== 3'd2 || tx_a !== 1'b0) begin
         bad++; $display("FAIL rmid_start got lvl=%0d tx=%b want 2/0", level_a, tx_a);
      end
      for (int c = 0; c < 4; c++) step();
      total++; if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
         bad++; $display("FAIL rmid_bit3 got tx=%b busy=%b want 0/1", tx_a, busy_a);
      end
      #2;
      reset = 1'b1;
      #1;
      total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL rmid_async_tx got=%b want=1", tx_a); end
      total++; if (level_a !== 3'd0 || busy_a !== 1'b0) begin
         bad++; $display("FAIL rmid_async_state got lvl=%0d busy=%b want 0/0", level_a, busy_a);
      end
      step(); step();
      reset = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step();
         total++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL rmid_after%0d got tx=%b busy=%b want 1/0", c, tx_a, busy_a);
         end
      end
   endtask

   task automatic test_ticks();
      logic [7:0] data;
      logic       exp_tx, exp_busy;
      int         bi;
      data = 8'h81;
      scaled_b = 1'b0;
      wb.wr_valid = 1'b1; wb.wr_data = data;
      step();
      wb.wr_valid = 1'b0;
      total++; if (level_b !== 3'd1) begin bad++; $display("FAIL ticks_write got=%0d want=1", level_b); end
      // Strobe on every 3rd edge: pop at edge 3, each bit spans 12 edges,
      // 11 bits end at edge 135.
      for (int k = 1; k <= 145; k++) begin
         scaled_b = ((k % 3) == 0);
         step();
         if (k < 3 || k >= 135) begin
            exp_tx = 1'b1; exp_busy = 1'b0;
         end else begin
            bi = (k - 3) / 12;
            exp_busy = 1'b1;
            if (bi == 0)      exp_tx = 1'b0;
            else if (bi <= 8) exp_tx = data[bi-1];
            else              exp_tx = 1'b1;
         end
         total++; if (tx_b !== exp_tx || busy_b !== exp_busy) begin
            bad++; $display("FAIL ticks_edge%0d got tx=%b busy=%b want tx=%b busy=%b", k, tx_b, busy_b, exp_tx, exp_busy);
         end
         if (k == 3) begin
            total++; if (level_b !== 3'd0) begin bad++; $display("FAIL ticks_pop got=%0d want=0", level_b); end
         end
      end
      scaled_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_push_pop();
      test_reset_mid();
      test_ticks();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
